audio_stream_avg: RTL and testbench



---
 rtl/audio_stream_pkg.sv | 27 ++
 rtl/audio_delay_line.sv | 27 ++
 rtl/audio_stream_avg.sv | 133 +++++++++++++
 tb/tb_audio_stream_avg.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_stream_pkg.sv
// Shared types and constants for the stereo moving-average stage.
// FSM encoding, mode values and window-size helpers live here.
package audio_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    EMIT   = 2'd2
  } state_t;

  localparam logic MODE_BYPASS = 1'b0;
  localparam logic MODE_AVG    = 1'b1;

  localparam int DEFAULT_DATA_W = 24;
  localparam int DEFAULT_LOG2_N = 3;

  // Number of taps in a window of 2^log2_n entries.
  function automatic int depth(input int log2_n);
    return 1 << log2_n;
  endfunction

  // Width of a counter that must reach exactly depth(log2_n).
  function automatic int fill_width(input int log2_n);
    return log2_n + 1;
  endfunction

endpackage

// File: rtl/audio_delay_line.sv
// Per-channel circular buffer of scaled samples: synchronous write,
// combinational read at the same shared address.
module audio_delay_line
  import audio_stream_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int LOG2_N = DEFAULT_LOG2_N
) (
  input  logic              clk,
  input  logic              we,
  input  logic [LOG2_N-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [depth(LOG2_N)];

  // NOTE: storage arrays take no reset; stale entries are masked by the
  // parent's fill count, and leaving them unreset lets them map to RAM.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read-before-write at the same address: rdata is the old entry this cycle.
  assign rdata = mem[addr];

endmodule

// File: rtl/audio_stream_avg.sv
// Stereo codec handshake stage: forwards each sample pair either raw or as
// an N-tap moving average per channel, selected by filter_en.
module audio_stream_avg
  import audio_stream_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int LOG2_N = DEFAULT_LOG2_N
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              filter_en,
  input  logic              read_ready,
  input  logic              write_ready,
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right,
  output logic [LOG2_N:0]   fill_count
);

  localparam int FILL_W = fill_width(LOG2_N);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(depth(LOG2_N));

  state_t state, state_next;

  logic capture;    // latch a new pair and pulse read
  logic do_update;  // advance the filter history
  logic emit_fire;  // present output and pulse write

  logic signed [DATA_W-1:0] sample_l, sample_r;
  logic signed [DATA_W-1:0] acc_l, acc_r;
  logic signed [DATA_W-1:0] scaled_l, scaled_r;
  logic signed [DATA_W-1:0] oldest_l, oldest_r;
  logic        [DATA_W-1:0] tap_l, tap_r;
  logic        [LOG2_N-1:0] wptr;
  logic                     window_full;

  // NOTE: every output of a combinational block gets a default first so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    do_update  = 1'b0;
    emit_fire  = 1'b0;
    unique case (state)
      IDLE: begin
        if (read_ready && write_ready) begin
          capture    = 1'b1;
          state_next = UPDATE;
        end
      end
      UPDATE: begin
        do_update  = 1'b1;
        state_next = EMIT;
      end
      EMIT: begin
        if (write_ready) begin
          emit_fire  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign window_full = (fill_count == FILL_MAX);

  // Arithmetic shift keeps the sign, so small negatives round toward -inf.
  assign scaled_l = sample_l >>> LOG2_N;
  assign scaled_r = sample_r >>> LOG2_N;
  assign oldest_l = window_full ? $signed(tap_l) : '0;
  assign oldest_r = window_full ? $signed(tap_r) : '0;

  audio_delay_line #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) u_line_left (
    .clk   (CLOCK_50),
    .we    (do_update),
    .addr  (wptr),
    .wdata (scaled_l),
    .rdata (tap_l)
  );

  audio_delay_line #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) u_line_right (
    .clk   (CLOCK_50),
    .we    (do_update),
    .addr  (wptr),
    .wdata (scaled_r),
    .rdata (tap_r)
  );

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      read            <= 1'b0;
      write           <= 1'b0;
      writedata_left  <= '0;
      writedata_right <= '0;
      sample_l        <= '0;
      sample_r        <= '0;
      acc_l           <= '0;
      acc_r           <= '0;
      wptr            <= '0;
      fill_count      <= '0;
    end else begin
      state <= state_next;
      read  <= capture;
      write <= emit_fire;

      if (capture) begin
        sample_l <= $signed(readdata_left);
        sample_r <= $signed(readdata_right);
      end

      if (do_update) begin
        acc_l <= acc_l + scaled_l - oldest_l;
        acc_r <= acc_r + scaled_r - oldest_r;
        wptr  <= wptr + 1'b1;
        if (!window_full) fill_count <= fill_count + 1'b1;
      end

      // Output registers only move on the write pulse, so they stay
      // stable while the codec stalls us in EMIT.
      if (emit_fire) begin
        writedata_left  <= (filter_en == MODE_AVG) ? acc_l : sample_l;
        writedata_right <= (filter_en == MODE_AVG) ? acc_r : sample_r;
      end
    end
  end

endmodule

// File: tb/tb_audio_stream_avg.sv
// Self-checking bench for audio_stream_avg (DATA_W=24, LOG2_N=2) against a
// queue-based model of the last N scaled samples per channel.
module tb_audio_stream_avg;

  localparam int DW = 24;
  localparam int LN = 2;
  localparam int N  = 1 << LN;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 filter_en;
  logic                 read_ready;
  logic                 write_ready;
  logic [DW-1:0]        din_l, din_r;
  logic                 read, write;
  logic signed [DW-1:0] wd_l, wd_r;
  logic [LN:0]          fill;

  int n_cmp  = 0;
  int n_fail = 0;

  int q_l[$];
  int q_r[$];

  audio_stream_avg #(.DATA_W(DW), .LOG2_N(LN)) dut (
    .CLOCK_50        (clk),
    .reset_n         (reset_n),
    .filter_en       (filter_en),
    .read_ready      (read_ready),
    .write_ready     (write_ready),
    .readdata_left   (din_l),
    .readdata_right  (din_r),
    .read            (read),
    .write           (write),
    .writedata_left  (wd_l),
    .writedata_right (wd_r),
    .fill_count      (fill)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Floor division by N: the value a single sample adds to the average.
  function automatic int scale(input int x);
    if (x >= 0) return x / N;
    return -((-x + N - 1) / N);
  endfunction

  function automatic int qsum(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  function automatic int rnd_sample();
    return int'($urandom_range(32'h00FF_FFFF, 0)) - (1 << 23);
  endfunction

  // Protocol-level rules checked every cycle.
  logic prev_read = 1'b0, prev_write = 1'b0;
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      chk("rw_exclusive", read & write, 0);
      chk("read_width", read & prev_read, 0);
      chk("write_width", write & prev_write, 0);
    end
    prev_read  = read;
    prev_write = write;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic model_clear();
    q_l.delete();
    q_r.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_read"}, read, 0);
    chk({tag, "_write"}, write, 0);
    chk({tag, "_wd_l"}, wd_l, 0);
    chk({tag, "_wd_r"}, wd_r, 0);
    chk({tag, "_fill"}, fill, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_between");
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
  endtask

  // One full handshake; stall holds write_ready low for that many cycles
  // after the read pulse.
  task automatic transact(input int l, input int r, input bit fen, input int stall);
    int el, er, ef;
    bit got;
    logic signed [DW-1:0] held_l, held_r;

    q_l.push_back(scale(l));
    q_r.push_back(scale(r));
    if (q_l.size() > N) void'(q_l.pop_front());
    if (q_r.size() > N) void'(q_r.pop_front());
    el = fen ? qsum(q_l) : l;
    er = fen ? qsum(q_r) : r;
    ef = q_l.size();

    @(negedge clk);
    din_l       = DW'(l);
    din_r       = DW'(r);
    filter_en   = fen;
    read_ready  = 1'b1;
    write_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (read === 1'b1) got = 1'b1;
    end
    chk("read_seen", got, 1);
    read_ready = 1'b0;

    if (stall > 0) begin
      write_ready = 1'b0;
      held_l = wd_l;
      held_r = wd_r;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk("stall_write", write, 0);
        chk("stall_read", read, 0);
        chk("stall_hold_l", wd_l, held_l);
        chk("stall_hold_r", wd_r, held_r);
      end
      write_ready = 1'b1;
      @(negedge clk);
      chk("write_after_stall", write, 1);
    end else begin
      @(negedge clk);
      chk("write_not_early", write, 0);
      @(negedge clk);
      chk("write_latency", write, 1);
    end
    chk("wd_left", wd_l, el);
    chk("wd_right", wd_r, er);
    chk("fill_count", fill, ef);
    @(negedge clk);
    chk("write_drop", write, 0);
  endtask

  initial begin
    bit got;
    reset_n     = 1'b0;
    filter_en   = 1'b1;
    read_ready  = 1'b0;
    write_ready = 1'b0;
    din_l       = '0;
    din_r       = '0;
    #5;
    check_reset_outputs("rst_init");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // No read while the codec cannot accept output.
    read_ready  = 1'b1;
    write_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_read_wr_low", read, 0);
    end
    read_ready  = 1'b0;
    write_ready = 1'b1;

    // Step response: 100,200,300,400,400,400 and the negative mirror.
    for (int i = 0; i < 6; i++) transact(400, -400, 1'b1, 0);
    chk("step_final_l", wd_l, 400);
    chk("step_final_r", wd_r, -400);

    // A lone -1 must contribute -1, not 0.
    do_reset();
    transact(0, -1, 1'b1, 0);
    chk("minus_one_r", wd_r, -1);

    // Bypass is exact, then averaging resumes from full history.
    transact(7, 7, 1'b0, 0);
    transact(-3, -3, 1'b0, 0);
    transact(1000, 1000, 1'b0, 0);
    transact(rnd_sample(), rnd_sample(), 1'b1, 0);

    // Codec stall in EMIT.
    transact(rnd_sample(), rnd_sample(), 1'b1, 10);

    // Reset while stalled in EMIT takes effect without a clock edge.
    @(negedge clk);
    din_l       = DW'(1234);
    din_r       = DW'(-1234);
    read_ready  = 1'b1;
    write_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (read === 1'b1) got = 1'b1;
    end
    chk("mid_read_seen", got, 1);
    read_ready  = 1'b0;
    write_ready = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid_emit");
    @(negedge clk);
    reset_n     = 1'b1;
    write_ready = 1'b1;
    model_clear();

    // Pointer wrap and eviction over 2N+1 samples.
    for (int i = 0; i < 2 * N + 1; i++) transact(rnd_sample(), rnd_sample(), 1'b1, 0);

    // Reset mid-priming: history restarts from zero.
    transact(rnd_sample(), rnd_sample(), 1'b1, 0);
    transact(rnd_sample(), rnd_sample(), 1'b1, 0);
    do_reset();
    for (int i = 0; i < 3; i++) transact(rnd_sample(), rnd_sample(), 1'b1, 0);

    // Mixed random traffic: modes, stalls and values.
    for (int i = 0; i < 30; i++)
      transact(rnd_sample(), rnd_sample(), 1'($urandom_range(1, 0)),
               int'($urandom_range(3, 0)));

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
